// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM write-burst gather path.
package sdram_pkg;

  localparam int SDRAM_DATA_W    = 16;
  localparam int SDRAM_ADDR_W    = 22;
  localparam int SDRAM_BURST_LEN = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Burst-length field must represent BURST_LEN itself, hence the extra bit.
  localparam int SDRAM_LEN_W = $clog2(SDRAM_BURST_LEN) + 1;
  typedef logic [SDRAM_LEN_W-1:0] burst_len_t;

  function automatic int len_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/sdram_burst_buf.sv
// BURST_LEN x DATA_W register file holding one gathered burst; contents are not reset.
module sdram_burst_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int IW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sdram_wr_burst_gather.sv
// Gathers FIFO write words into one SDRAM write burst, requests it, then streams it.
// Optional partial-burst flush on idle: define SDRAM_WR_FLUSH_TIMEOUT_EN.
module sdram_wr_burst_gather
  import sdram_pkg::*;
#(
  parameter int DATA_W    = SDRAM_DATA_W,
  parameter int BURST_LEN = SDRAM_BURST_LEN,
  parameter int ADDR_W    = SDRAM_ADDR_W,
  parameter int TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [DATA_W-1:0]          fifo_data,
  output logic                       fifo_pull,
  input  logic                       cfg_load,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       burst_valid,
  input  logic                       burst_ready,
  output logic [ADDR_W-1:0]          burst_addr,
  output logic [$clog2(BURST_LEN):0] burst_len,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       wr_data_valid,
  output logic                       busy
);

  localparam int LW = $clog2(BURST_LEN) + 1;
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(BURST_LEN);
  localparam logic [LW-1:0] LAST_CNT = LW'(BURST_LEN - 1);

  localparam logic [1:0] ST_FILL   = 2'(FILL);
  localparam logic [1:0] ST_ISSUE  = 2'(ISSUE);
  localparam logic [1:0] ST_STREAM = 2'(STREAM);

  logic [1:0]        state_reg;
  logic [LW-1:0]     pull_cnt_reg;
  logic [LW-1:0]     cap_cnt_reg;
  logic [LW-1:0]     rd_idx_reg;
  logic              pull_d_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              wr_valid_reg;

  logic [DATA_W-1:0] buf_rd_data;
  logic [IW-1:0]     buf_rd_idx;
  logic              in_fill;
  logic              cfg_ok;
  logic              stream_last;
  logic              fill_done;
  logic              flush;

  assign in_fill     = (state_reg == ST_FILL);
  // Gated by rst so the pop request is low while reset is held.
  assign fifo_pull   = rst && in_fill && !fifo_empty && (pull_cnt_reg < FULL_CNT);
  assign cfg_ok      = in_fill && (pull_cnt_reg == '0);
  assign fill_done   = in_fill && pull_d_reg && (cap_cnt_reg == LAST_CNT);
  assign stream_last = (state_reg == ST_STREAM) && (rd_idx_reg == cap_cnt_reg);
  // Word 0 is fetched at the handshake edge; later words follow rd_idx_reg.
  assign buf_rd_idx  = (state_reg == ST_ISSUE) ? '0 : rd_idx_reg[IW-1:0];

  assign burst_valid   = (state_reg == ST_ISSUE);
  assign burst_addr    = addr_reg;
  assign burst_len     = cap_cnt_reg;
  assign wr_data       = wr_data_reg;
  assign wr_data_valid = wr_valid_reg;
  assign busy          = !in_fill || (pull_cnt_reg != '0);

  sdram_burst_buf #(
    .DEPTH  (BURST_LEN),
    .DATA_W (DATA_W),
    .IW     (IW)
  ) u_buf (
    .clk     (clk),
    .we      (pull_d_reg),
    .wr_idx  (cap_cnt_reg[IW-1:0]),
    .wr_data (fifo_data),
    .rd_idx  (buf_rd_idx),
    .rd_data (buf_rd_data)
  );

`ifdef SDRAM_WR_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_cnt_reg;
  logic          idle_run;

  // With pull_d low and the FIFO empty no pop is in flight, so pull_cnt equals cap_cnt.
  assign idle_run = in_fill && (cap_cnt_reg != '0) && !pull_d_reg && fifo_empty;
  assign flush    = idle_run && (idle_cnt_reg == IDLE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_reg <= '0;
    end else if (idle_run && !flush) begin
      idle_cnt_reg <= idle_cnt_reg + TW'(1);
    end else begin
      idle_cnt_reg <= '0;
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_FILL;
      pull_cnt_reg <= '0;
      cap_cnt_reg  <= '0;
      rd_idx_reg   <= '0;
      pull_d_reg   <= 1'b0;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      wr_valid_reg <= 1'b0;
    end else begin
      pull_d_reg <= fifo_pull;
      if (fifo_pull)          pull_cnt_reg <= pull_cnt_reg + LW'(1);
      if (pull_d_reg)         cap_cnt_reg  <= cap_cnt_reg + LW'(1);
      if (cfg_load && cfg_ok) addr_reg     <= base_addr;

      case (state_reg)
        ST_FILL: begin
          if (fill_done || flush) state_reg <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (burst_ready) begin
            state_reg    <= ST_STREAM;
            wr_data_reg  <= buf_rd_data;
            wr_valid_reg <= 1'b1;
            rd_idx_reg   <= LW'(1);
          end
        end
        ST_STREAM: begin
          if (stream_last) begin
            state_reg    <= ST_FILL;
            wr_valid_reg <= 1'b0;
            addr_reg     <= addr_reg + ADDR_W'(cap_cnt_reg);
            pull_cnt_reg <= '0;
            cap_cnt_reg  <= '0;
            rd_idx_reg   <= '0;
          end else begin
            wr_data_reg <= buf_rd_data;
            rd_idx_reg  <= rd_idx_reg + LW'(1);
          end
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

endmodule
